sm_job_scheduler: RTL and testbench
===================================

SM_JOB_SCHEDULER -- requirements
Module: sm_job_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one compute unit (1..8).
REQ-002 Parameter TIMEOUT, default 15, maximum cycles spent waiting for cu_done before an error response.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester job request.
REQ-006 req_data  input  NUM_REQ*16  per-requester signed 16-bit operand; lane i occupies bits [16i+15:16i].
REQ-007 req_ready  output  NUM_REQ  one-hot grant; the job is accepted on any edge where req_valid[i] and req_ready[i] are both high.
REQ-008 cu_start  output  1  start pulse to the compute unit.
REQ-009 cu_x  output  16  signed operand to the compute unit.
REQ-010 cu_y  input  32  signed result from the compute unit, valid while cu_done is high.
REQ-011 cu_done  input  1  single-cycle completion strobe from the compute unit.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  $clog2(NUM_REQ) (min 1)  index of the requester that owns the response.
REQ-015 rsp_data  output  32  signed result.
REQ-016 rsp_err  output  1  response caused by timeout.
REQ-017 busy  output  1  high in every state except S_IDLE.

Function
REQ-018 The FSM SHALL have the states S_IDLE, S_ISSUE, S_WAIT and S_RESP.
REQ-019 In S_IDLE with any req_valid high, req_ready SHALL be asserted (combinationally) for exactly one lane: the first valid lane at or after the round-robin pointer, wrapping from NUM_REQ-1 to 0.
REQ-020 On acceptance, the block SHALL register the lane index and operand, and the state SHALL move to S_ISSUE.
REQ-021 In every state other than S_IDLE, req_ready SHALL be all zero.
REQ-022 In S_ISSUE, cu_start SHALL be 1 for exactly one cycle, with cu_x equal to the captured operand; the state SHALL then move to S_WAIT and the timeout counter SHALL clear to 0.
REQ-023 cu_x SHALL hold the last captured operand at all times; cu_start SHALL be 0 in every state except S_ISSUE.
REQ-024 In S_WAIT, cu_done=1 SHALL capture cu_y into rsp_data, clear rsp_err, and move the state to S_RESP.
REQ-025 In S_WAIT without cu_done, the counter SHALL increment each cycle. When it equals TIMEOUT, rsp_data SHALL be set to 0, rsp_err to 1, and the state SHALL move to S_RESP.
REQ-026 If cu_done and the timeout condition occur in the same cycle, cu_done SHALL win.
REQ-027 cu_done outside S_WAIT SHALL be ignored.
REQ-028 In S_RESP, rsp_valid SHALL be 1, and rsp_id, rsp_data and rsp_err SHALL remain stable until rsp_ready is high.
REQ-029 When rsp_ready is high in S_RESP, the pointer SHALL become (rsp_id+1) mod NUM_REQ and the state SHALL return to S_IDLE. With NUM_REQ=1 the pointer stays 0.
REQ-030 With a compute unit that raises cu_done 4 cycles after sampling cu_start, rsp_valid SHALL first be high 6 edges after the acceptance edge.
REQ-031 Requesters SHALL hold req_valid and req_data stable until accepted; the bench checks this rule, and the block does not police it.

Reset
REQ-032 While rst_n is low, the block SHALL hold these values: state S_IDLE, pointer 0, captured operand and index 0, counter 0, cu_start 0, cu_x 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, busy 0.
REQ-033 Reset asserted mid-job SHALL drop the job without generating a response; after release the block SHALL accept new requests from S_IDLE.

Structure
REQ-034 A shared package sm_sched_pkg SHALL hold the state enum, X_W=16 and Y_W=32.
REQ-035 Lane selection SHALL be a sub-module rr_arbiter, which takes the request vector and pointer and returns a one-hot grant plus an index.

Verification
REQ-036 Single job: lane 0, x=10, rsp_ready held high -> rsp_id=0, rsp_data=38, rsp_err=0, rsp_valid 6 edges after acceptance.
REQ-037 All four lanes valid at once with x=0, -5, 1, -32768 -> responses in order ids 0,1,2,3 with data 8, -7, 11, -98296.
REQ-038 Fairness: lanes 1 and 3 continuously valid, pointer at 2 -> grants alternate 3,1,3,1.
REQ-039 Compute unit never raises cu_done -> rsp_err=1, rsp_data=0 after TIMEOUT cycles in S_WAIT; the next job then completes normally.
REQ-040 rsp_ready held low 10 cycles -> rsp_valid, rsp_id and rsp_data stay stable, req_ready stays 0, and no cu_start is issued.
REQ-041 rst_n pulsed low during S_WAIT -> all outputs return to their reset values immediately, no response is produced, and a following lane 2 job with x=3 returns 17.

Source files
------------

// File: rtl/sm_sched_pkg.sv
// ---------------------------------------------------------------------------
// sm_sched_pkg
// Shared definitions for the job scheduler: FSM state encoding and the
// operand / result widths of the compute-unit interface.
// ---------------------------------------------------------------------------
package sm_sched_pkg;

    localparam int X_W = 16;   // operand width (signed)
    localparam int Y_W = 32;   // result width (signed)

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/sm_job_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin lane selector.
// Picks the first requesting lane at or after ptr, wrapping from N-1 to 0.
//
// Ports
//   req   in  [N-1:0]      request vector
//   ptr   in  [IDX_W-1:0]  highest-priority lane for this decision
//   grant out [N-1:0]      one-hot grant (all zero when no request)
//   idx   out [IDX_W-1:0]  binary index of the granted lane (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] at_or_above_ptr;
    logic [N-1:0] masked_req;
    logic [N-1:0] pick;

    // Lanes whose index is >= ptr form the first search window; if none of
    // them request, the search wraps to the full vector starting at lane 0.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign at_or_above_ptr[gi] = (gi >= int'(ptr));
        end
    endgenerate

    assign masked_req = req & at_or_above_ptr;
    assign pick       = (|masked_req) ? masked_req : req;

    // Isolate the lowest set bit of the chosen window.
    assign grant = pick & (~pick + {{(N-1){1'b0}}, 1'b1});

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sm_job_scheduler.sv
// ---------------------------------------------------------------------------
// sm_job_scheduler
// Shares one compute unit between NUM_REQ requesters. A job is accepted from
// the round-robin winner, issued to the compute unit with a one-cycle start
// pulse, and its result (or a timeout error) is returned on a valid/ready
// response channel tagged with the owning requester index.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]       per-lane job request
//   req_data   in   [NUM_REQ*16]    per-lane signed operand, lane i at [16i+:16]
//   req_ready  out  [NUM_REQ]       one-hot accept, only in S_IDLE
//   cu_start   out  start pulse to the compute unit
//   cu_x       out  [16]            operand to the compute unit
//   cu_y       in   [32]            result, valid with cu_done
//   cu_done    in   completion strobe
//   rsp_valid  out  response available
//   rsp_ready  in   response accepted
//   rsp_id     out  [IDX_W]         requester owning the response
//   rsp_data   out  [32]            signed result (0 on timeout)
//   rsp_err    out  response caused by timeout
//   busy       out  high outside S_IDLE
// ---------------------------------------------------------------------------
module sm_job_scheduler
    import sm_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 15,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*X_W-1:0] req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   cu_start,
    output logic [X_W-1:0]         cu_x,
    input  logic [Y_W-1:0]         cu_y,
    input  logic                   cu_done,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDX_W-1:0]       rsp_id,
    output logic [Y_W-1:0]         rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    // Counter must be able to hold TIMEOUT itself.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [X_W-1:0]     x_q,     x_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [Y_W-1:0]     data_q,  data_d;
    logic               err_q,   err_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [X_W-1:0]     lane_x [NUM_REQ];
    logic [X_W-1:0]     sel_x;
    logic [CNT_W-1:0]   cnt_inc;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_x[gi] = req_data[gi*X_W +: X_W];
        end
    endgenerate

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    // One-hot operand mux driven by the grant.
    always_comb begin
        sel_x = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_x = lane_x[i];
            end
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_inc = cnt_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                // A non-zero grant implies the granted lane is valid, so
                // the grant itself is the acceptance condition.
                if (|grant) begin
                    idx_d   = grant_idx;
                    x_d     = sel_x;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // cu_done is checked first so it wins over a coincident timeout.
                if (cu_done) begin
                    data_d  = cu_y;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        req_ready = '0;
        cu_start  = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                req_ready = grant;
                busy      = 1'b0;
            end
            S_ISSUE: cu_start  = 1'b1;
            S_WAIT:  ;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign cu_x     = x_q;
    assign rsp_id   = idx_q;
    assign rsp_data = data_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_sm_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sm_job_scheduler
// Self-checking bench for sm_job_scheduler. A behavioural compute unit
// returns y = 3*x + 8 a programmable number of cycles after it samples
// cu_start (0 = never answers). A transaction-level model predicts grants,
// the response contents and the edge on which each response appears.
// ---------------------------------------------------------------------------
module tb_sm_job_scheduler;

    localparam int N   = 4;
    localparam int TMO = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*16-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            cu_start;
    logic [15:0]     cu_x;
    logic [31:0]     cu_y = '0;
    logic            cu_done = 1'b0;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic            busy;

    sm_job_scheduler #(
        .NUM_REQ (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cu_start  (cu_start),
        .cu_x      (cu_x),
        .cu_y      (cu_y),
        .cu_done   (cu_done),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural compute unit ----------------
    int          cu_delay = 4;
    int          cu_wait  = 0;
    logic [15:0] cu_xs    = '0;

    always @(posedge clk) begin
        cu_done <= 1'b0;
        cu_y    <= $urandom;
        if (cu_start) begin
            cu_wait <= cu_delay;
            cu_xs   <= cu_x;
        end else if (cu_wait > 0) begin
            cu_wait <= cu_wait - 1;
            if (cu_wait == 1) begin
                cu_done <= 1'b1;
                cu_y    <= 32'(3 * int'($signed(cu_xs)) + 8);
            end
        end
    end

    // ---------------- model / scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        m_busy = 1'b0;
    int          m_ptr = 0;
    logic [15:0] m_last_x = '0;
    int          acc_edge = 0;
    int          lat = 0;
    int          exp_id = 0;
    logic [31:0] exp_data = '0;
    logic        exp_err = 1'b0;
    logic [N-1:0] pend_v = '0;
    logic [N-1:0] sticky = '0;
    logic [15:0] pend_x [N];
    int          force_delay = -1;
    int          grant_log[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // First pending lane at or after p, wrapping.
    function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v, input int p);
        logic [N-1:0] one;
        one = 1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return one << ((p + k) % N);
        end
        return '0;
    endfunction

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(9));
        case (r)
            0:       return 0;         // never completes
            1:       return TMO - 1;   // completes on the timeout cycle
            2:       return TMO;       // one cycle too late
            3:       return TMO - 2;
            default: return int'($urandom_range(8, 1));
        endcase
    endfunction

    task automatic post(input int lane, input logic [15:0] x);
        pend_v[lane] = 1'b1;
        pend_x[lane] = x;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_busy",      busy,      0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_cu_start",  cu_start,  0);
        check_eq("rst_cu_x",      cu_x,      0);
        check_eq("rst_rsp_id",    rsp_id,    0);
        check_eq("rst_rsp_data",  rsp_data,  0);
        check_eq("rst_rsp_err",   rsp_err,   0);
        check_eq("rst_req_ready", req_ready, 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        pend_v    = '0;
        req_valid = '0;
        rsp_ready = 1'b0;
        m_busy    = 1'b0;
        m_ptr     = 0;
        m_last_x  = '0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        $display("reset pulse at cycle %0d", cyc);
    endtask

    // One clock cycle: drive inputs after the edge, then check and advance the model.
    task automatic step(input int p_new, input int p_rdy);
        logic [N-1:0] g;
        int c;
        int d;
        int lane;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && (sticky[i] || ($urandom_range(99) < p_new))) begin
                pend_v[i] = 1'b1;
                pend_x[i] = 16'($urandom);
            end
        end
        req_valid = pend_v;
        for (int i = 0; i < N; i++) req_data[16*i +: 16] = pend_x[i];
        rsp_ready = ($urandom_range(99) < p_rdy);
        #1;
        check_eq("cu_x", cu_x, m_last_x);
        if (!m_busy) begin
            g = exp_grant(pend_v, m_ptr);
            check_eq("req_ready", req_ready, g);
            check_eq("busy_idle", busy, 0);
            check_eq("rsp_valid_idle", rsp_valid, 0);
            check_eq("cu_start_idle", cu_start, 0);
            if (g != 0) begin
                lane = 0;
                for (int i = 0; i < N; i++) if (g[i]) lane = i;
                d        = (force_delay >= 0) ? force_delay : pick_delay();
                cu_delay = d;
                m_busy   = 1'b1;
                acc_edge = cyc + 1;
                exp_id   = lane;
                m_last_x = pend_x[lane];
                pend_v[lane] = 1'b0;
                if (d >= 1 && d < TMO) begin
                    exp_data = 32'(3 * int'($signed(pend_x[lane])) + 8);
                    exp_err  = 1'b0;
                    lat      = d + 2;
                end else begin
                    exp_data = '0;
                    exp_err  = 1'b1;
                    lat      = TMO + 1;
                end
                grant_log.push_back(lane);
            end
        end else begin
            c = cyc - acc_edge;
            check_eq("req_ready_busy", req_ready, 0);
            check_eq("busy", busy, 1);
            check_eq("cu_start", cu_start, (c == 0));
            check_eq("rsp_valid", rsp_valid, (c >= lat));
            if (c >= lat) begin
                check_eq("rsp_id",   rsp_id,   exp_id);
                check_eq("rsp_data", rsp_data, exp_data);
                check_eq("rsp_err",  rsp_err,  exp_err);
                if (rsp_ready) begin
                    $display("rsp id=%0d data=%0d err=%0b edges_after_accept=%0d",
                             rsp_id, $signed(rsp_data), rsp_err, c);
                    m_busy = 1'b0;
                    m_ptr  = (exp_id + 1) % N;
                end
            end
        end
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((m_busy || pend_v != 0) && n < maxc) begin
            step(0, 100);
            n++;
        end
        check_eq("drain_bound", (m_busy || pend_v != 0), 0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) pend_x[i] = '0;
        #2;
        do_reset();

        // All four lanes at once from pointer 0.
        grant_log.delete();
        force_delay = 4;
        post(0, 16'd0);
        post(1, 16'hFFFB);
        post(2, 16'd1);
        post(3, 16'h8000);
        drain(200);
        check_eq("all4_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++) check_eq("all4_order", grant_log[k], k);

        // Single job on lane 0, x = 10.
        post(0, 16'd10);
        drain(100);

        // Fairness: move pointer to 2, then lanes 1 and 3 continuously valid.
        post(1, 16'd2);
        drain(100);
        grant_log.delete();
        sticky = 4'b1010;
        n = 0;
        while (grant_log.size() < 4 && n < 300) begin
            step(0, 100);
            n++;
        end
        sticky = '0;
        drain(200);
        check_eq("fair_count", (grant_log.size() >= 4), 1);
        check_eq("fair_g0", grant_log[0], 3);
        check_eq("fair_g1", grant_log[1], 1);
        check_eq("fair_g2", grant_log[2], 3);
        check_eq("fair_g3", grant_log[3], 1);

        // Compute unit never answers, then a normal job; then the
        // completes-on-timeout-cycle and one-cycle-late boundaries.
        force_delay = 0;  post(2, 16'h1234); drain(100);
        force_delay = 4;  post(2, 16'd7);    drain(100);
        force_delay = TMO - 1; post(1, 16'hFF00); drain(100);
        force_delay = TMO;     post(3, 16'd99);   drain(100);

        // Consumer stalls while other lanes are requesting.
        force_delay = 4;
        post(0, 16'd100);
        repeat (16) step(0, 0);
        post(1, 16'd5);
        post(3, 16'd6);
        repeat (10) step(0, 0);
        drain(200);

        // Reset while waiting on the compute unit.
        force_delay = 8;
        post(1, 16'd55);
        n = 0;
        while (!(m_busy && (cyc - acc_edge) == 3) && n < 30) begin
            step(0, 100);
            n++;
        end
        check_eq("reached_wait", (m_busy && (cyc - acc_edge) == 3), 1);
        do_reset();
        repeat (20) step(0, 0);     // stale cu_done arrives while idle
        force_delay = 4;
        post(2, 16'd3);
        drain(100);

        // Randomised traffic.
        force_delay = -1;
        repeat (1500) step(30, 60);
        drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
